// File: rtl/config_memory_pkg.sv
// Shared record layout and state encoding for the config BRAM writer.
// The word layout must match what the boot loader reads back.
package config_memory_pkg;

    localparam int WORDS_PER_CHANNEL = 6;
    localparam int OFS_IP            = 0;
    localparam int OFS_NETMASK       = 1;
    localparam int OFS_GATEWAY       = 2;
    localparam int OFS_TARGETIP      = 3;
    localparam int OFS_MAC_HI        = 4;
    localparam int OFS_MAC_LO        = 5;
    localparam int CFG_ADDR_W        = 10;

    typedef enum logic [1:0] {IDLE, WRITE, VERIFY, RESP} state_e;

    typedef struct packed {
        logic [31:0] ipaddr;
        logic [31:0] netmask;
        logic [31:0] gateway;
        logic [31:0] targetip;
        logic [47:0] macaddr;
    } cfg_rec_t;

    function automatic logic [31:0] rec_word(input logic [2:0] k, input cfg_rec_t f);
        logic [31:0] w;
        w = 32'h0;
        case (int'(k))
            OFS_IP:       w = f.ipaddr;
            OFS_NETMASK:  w = f.netmask;
            OFS_GATEWAY:  w = f.gateway;
            OFS_TARGETIP: w = f.targetip;
            OFS_MAC_HI:   w = f.macaddr[47:16];
            OFS_MAC_LO:   w = {f.macaddr[15:0], 16'h0000};
            default:      w = 32'h0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/config_readback_checker.sv
// Carries expected words alongside the BRAM read latency and compares them
// with read data when it emerges; errors stick until cleared.
module config_readback_checker
    import config_memory_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_i,
    input  logic        last_i,
    input  logic        clear_i,
    input  logic [31:0] exp_i,
    input  logic [31:0] dout_i,
    output logic        err_o,
    output logic        last_done_o
);

    typedef struct packed {
        logic        vld;
        logic        last;
        logic [31:0] exp;
    } slot_t;

    slot_t [READ_LATENCY-1:0] line_q;
    logic                     err_q;
    slot_t                    head;

    assign head = line_q[READ_LATENCY-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            line_q <= '0;
            err_q  <= 1'b0;
        end else begin
            line_q[0] <= slot_t'{vld: issue_i, last: issue_i & last_i, exp: exp_i};
            for (int i = 1; i < READ_LATENCY; i++) line_q[i] <= line_q[i-1];
            if (clear_i)
                err_q <= 1'b0;
            else if (head.vld && (dout_i != head.exp))
                err_q <= 1'b1;
        end
    end

    assign err_o       = err_q;
    assign last_done_o = head.vld & head.last;

endmodule

// File: rtl/config_memory_writer.sv
// Commits one channel's network record into the config BRAM via port B,
// reads it back for verification and returns a single pass/fail response.
module config_memory_writer
    import config_memory_pkg::*;
#(
    parameter int NUM_CHANNELS = 8,
    parameter int BASE_ADDR    = 0,
    parameter int READ_LATENCY = 2,
    parameter int ADDR_W       = CFG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_channel,
    input  logic              req_clear,
    input  logic [31:0]       req_ipaddr,
    input  logic [31:0]       req_netmask,
    input  logic [31:0]       req_gateway,
    input  logic [31:0]       req_targetip,
    input  logic [47:0]       req_macaddr,
    output logic              resp_valid,
    output logic              resp_error,
    output logic              busy,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_din,
    input  logic [31:0]       bram_dout
);

    state_e            state_q, state_d;
    logic [2:0]        beat_q, beat_d;
    cfg_rec_t          rec_q, rec_d, rec_new;
    logic [ADDR_W-1:0] base_q, base_d, base_new;
    logic              bad_q, bad_d;
    logic              en_q, en_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       din_q, din_d;

    logic accept, chk_issue, chk_last, chk_err, chk_done;

    assign req_ready = (state_q == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    assign rec_new  = req_clear ? '0 :
                      cfg_rec_t'{ipaddr: req_ipaddr, netmask: req_netmask,
                                 gateway: req_gateway, targetip: req_targetip,
                                 macaddr: req_macaddr};
    assign base_new = ADDR_W'(BASE_ADDR) + ADDR_W'(req_channel) * ADDR_W'(WORDS_PER_CHANNEL);

    // Beat 6 in VERIFY means all reads are issued and we only await the last compare.
    assign chk_issue = (state_q == VERIFY) && (beat_q <= 3'd5);
    assign chk_last  = (beat_q == 3'd5);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        rec_d   = rec_q;
        base_d  = base_q;
        bad_d   = bad_q;
        en_d    = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rec_d  = rec_new;
                    base_d = base_new;
                    beat_d = 3'd0;
                    if (int'(req_channel) < NUM_CHANNELS) begin
                        bad_d   = 1'b0;
                        state_d = WRITE;
                        en_d    = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = base_new;
                        din_d   = rec_word(3'd0, rec_new);
                    end else begin
                        bad_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            WRITE: begin
                en_d = 1'b1;
                if (beat_q == 3'd5) begin
                    state_d = VERIFY;
                    beat_d  = 3'd0;
                    addr_d  = base_q;
                end else begin
                    beat_d = beat_q + 3'd1;
                    we_d   = 1'b1;
                    addr_d = base_q + ADDR_W'(beat_q + 3'd1);
                    din_d  = rec_word(beat_q + 3'd1, rec_q);
                end
            end
            VERIFY: begin
                if (beat_q < 3'd5) begin
                    beat_d = beat_q + 3'd1;
                    en_d   = 1'b1;
                    addr_d = base_q + ADDR_W'(beat_q + 3'd1);
                end else begin
                    beat_d = 3'd6;
                end
                if (chk_done) state_d = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= 3'd0;
            rec_q   <= '0;
            base_q  <= '0;
            bad_q   <= 1'b0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            rec_q   <= rec_d;
            base_q  <= base_d;
            bad_q   <= bad_d;
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    config_readback_checker #(.READ_LATENCY(READ_LATENCY)) u_chk (
        .clk         (clk),
        .reset       (reset),
        .issue_i     (chk_issue),
        .last_i      (chk_last),
        .clear_i     (accept),
        .exp_i       (rec_word(beat_q, rec_q)),
        .dout_i      (bram_dout),
        .err_o       (chk_err),
        .last_done_o (chk_done)
    );

    assign resp_valid = (state_q == RESP);
    assign resp_error = (state_q == RESP) && (bad_q || chk_err);
    assign busy       = (state_q != IDLE);
    assign bram_en    = en_q;
    assign bram_we    = we_q;
    assign bram_addr  = addr_q;
    assign bram_din   = din_q;

endmodule

// File: tb/tb_config_memory_writer.sv
// Bench for config_memory_writer: behavioural latency-2 BRAM, vector table
// of commits, response scoreboard, and hand sequences for reset and back-to-back.
module tb_config_memory_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_clear = 1'b0;
    logic [3:0]  req_channel = 4'd0;
    logic [31:0] req_ipaddr = '0, req_netmask = '0, req_gateway = '0, req_targetip = '0;
    logic [47:0] req_macaddr = '0;
    logic        resp_valid, resp_error, busy, bram_en, bram_we;
    logic [9:0]  bram_addr;
    logic [31:0] bram_din, bram_dout;

    always #5 clk = ~clk;

    config_memory_writer dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_channel(req_channel), .req_clear(req_clear), .req_ipaddr(req_ipaddr),
        .req_netmask(req_netmask), .req_gateway(req_gateway), .req_targetip(req_targetip),
        .req_macaddr(req_macaddr), .resp_valid(resp_valid), .resp_error(resp_error),
        .busy(busy), .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout)
    );

    // Behavioural port-B BRAM, read-first, two-cycle read latency.
    logic [31:0] mem [0:1023];
    logic [31:0] rd1 = '0, rd2 = '0;
    logic        corrupt = 1'b0, init_mem = 1'b0;
    int          cyc = 0, wr_cnt = 0, rd_cnt = 0;

    always @(posedge clk) begin
        if (init_mem)
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hA5000000 | 32'(i);
        else if (bram_en) begin
            rd1 <= (corrupt && bram_addr == 10'd16) ? (mem[bram_addr] ^ 32'h1) : mem[bram_addr];
            if (bram_we) mem[bram_addr] <= bram_din;
        end
        rd2 <= rd1;
    end
    assign bram_dout = rd2;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bram_en && !reset) begin
            if (bram_we) wr_cnt <= wr_cnt + 1;
            else         rd_cnt <= rd_cnt + 1;
        end
    end

    int total = 0, passed = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    typedef struct {
        logic [3:0]  ch;
        logic        clear;
        logic [31:0] ip, mask, gw, tgt;
        logic [47:0] mac;
        logic        corrupt;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct { logic err; int cyc; } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (!reset && resp_valid) begin
            if (sbq.size() == 0) chk("unexpected_resp", 1, 0);
            else begin
                mon_e = sbq.pop_front();
                chk("resp_error", resp_error, mon_e.err);
                chk("resp_cycle", cyc, mon_e.cyc);
            end
        end
    end

    function automatic logic [31:0] exp_word(input vec_t v, input int k);
        if (v.clear) return 32'h0;
        case (k)
            0: return v.ip;
            1: return v.mask;
            2: return v.gw;
            3: return v.tgt;
            4: return v.mac[47:16];
            default: return {v.mac[15:0], 16'h0000};
        endcase
    endfunction

    function automatic logic [31:0] sentinel(input int a);
        return 32'hA5000000 | 32'(a);
    endfunction

    task automatic drive(input vec_t v);
        req_channel  = v.ch;
        req_clear    = v.clear;
        req_ipaddr   = v.ip;
        req_netmask  = v.mask;
        req_gateway  = v.gw;
        req_targetip = v.tgt;
        req_macaddr  = v.mac;
    endtask

    // Presents v at a negedge, waits (bounded) for acceptance; t_acc is the accept cycle.
    task automatic commit(input vec_t v, input bit exp_resp, input bit hold, output int t_acc);
        @(negedge clk);
        drive(v);
        req_valid = 1'b1;
        t_acc = -1;
        for (int i = 0; i < 40 && t_acc < 0; i++) begin
            if (req_ready) t_acc = cyc;
            else @(negedge clk);
        end
        if (t_acc < 0) chk("accept_timeout", 0, 1);
        else if (exp_resp) sbq.push_back('{err: v.exp_err, cyc: t_acc + v.exp_lat});
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sbq.size() != 0 || busy) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            chk("resp_timeout", 0, 1);
            sbq.delete();
        end
        @(negedge clk);
    endtask

    vec_t vecs[8];
    vec_t va, vb;
    int   t, t1, t2, w0, r0;

    initial begin
        vecs[0] = '{4'd0, 1'b0, 32'h0a0300fe, 32'hffff0000, 32'h0a030001, 32'h0a030002, 48'h001b1a000010, 1'b0, 1'b0, 15};
        vecs[1] = '{4'd7, 1'b1, 32'h12345678, 32'h9abcdef0, 32'h0badf00d, 32'hcafef00d, 48'h112233445566, 1'b0, 1'b0, 15};
        vecs[2] = '{4'd9, 1'b0, 32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404, 48'h050505050505, 1'b0, 1'b1, 1};
        vecs[3] = '{4'd2, 1'b0, 32'hc0a80101, 32'hffffff00, 32'hc0a801fe, 32'hc0a80102, 48'h0200deadbeef, 1'b1, 1'b1, 15};
        vecs[4] = '{4'd15, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 48'h555555555555, 1'b0, 1'b1, 1};
        vecs[5] = '{4'd1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 48'h0, 1'b0, 1'b0, 15};
        vecs[6] = '{4'd6, 1'b0, 32'hffffffff, 32'h80000000, 32'h00000001, 32'h7fffffff, 48'hfedcba987654, 1'b0, 1'b0, 15};
        vecs[7] = '{4'd8, 1'b0, 32'h0a000001, 32'hff000000, 32'h0a0000fe, 32'h0a000002, 48'h001122334455, 1'b0, 1'b1, 1};

        reset = 1'b1;
        init_mem = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_error", resp_error, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bram_en", bram_en, 0);
        chk("rst_bram_we", bram_we, 0);
        chk("rst_bram_addr", bram_addr, 0);
        chk("rst_bram_din", bram_din, 0);
        init_mem = 1'b0;
        reset = 1'b0;
        #1;
        chk("post_rst_ready", req_ready, 1);

        for (int n = 0; n < 8; n++) begin
            w0 = wr_cnt;
            r0 = rd_cnt;
            corrupt = vecs[n].corrupt;
            commit(vecs[n], 1'b1, 1'b0, t);
            wait_idle();
            corrupt = 1'b0;
            if (vecs[n].ch < 8) begin
                for (int k = 0; k < 6; k++)
                    chk($sformatf("v%0d_word%0d", n, k), mem[6*int'(vecs[n].ch) + k], exp_word(vecs[n], k));
                chk($sformatf("v%0d_writes", n), wr_cnt - w0, 6);
                chk($sformatf("v%0d_reads", n), rd_cnt - r0, 6);
            end else begin
                chk($sformatf("v%0d_no_bram", n), (wr_cnt - w0) + (rd_cnt - r0), 0);
            end
            if (n == 0) begin
                chk("idle_bram_en", bram_en, 0);
                chk("addr_hold", bram_addr, 5);
                chk("din_hold", bram_din, 32'h00100000);
            end
        end

        // Reset during the WRITE phase of ch3: first four words land, last two untouched.
        va = '{4'd3, 1'b0, 32'haaaa0001, 32'haaaa0002, 32'haaaa0003, 32'haaaa0004, 48'haaaa0005bbbb, 1'b0, 1'b0, 15};
        commit(va, 1'b0, 1'b0, t);
        while (cyc < t + 4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_bram_en", bram_en, 0);
        chk("midrst_resp_valid", resp_valid, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        for (int k = 0; k < 4; k++)
            chk($sformatf("midrst_word%0d", k), mem[18 + k], exp_word(va, k));
        chk("midrst_word4", mem[22], sentinel(22));
        chk("midrst_word5", mem[23], sentinel(23));
        vb = '{4'd3, 1'b0, 32'h0a0a0a0a, 32'hfffffff0, 32'h0a0a0a01, 32'h0a0a0a02, 48'h0000c0ffee01, 1'b0, 1'b0, 15};
        commit(vb, 1'b1, 1'b0, t);
        wait_idle();
        for (int k = 0; k < 6; k++)
            chk($sformatf("postrst_word%0d", k), mem[18 + k], exp_word(vb, k));

        // Back-to-back with req_valid held; fields toggled while busy.
        va = '{4'd4, 1'b0, 32'h44440001, 32'h44440002, 32'h44440003, 32'h44440004, 48'h444400054444, 1'b0, 1'b0, 15};
        vb = '{4'd5, 1'b0, 32'h55550001, 32'h55550002, 32'h55550003, 32'h55550004, 48'h555500055555, 1'b0, 1'b0, 15};
        commit(va, 1'b1, 1'b1, t1);
        while (cyc < t1 + 10) begin
            req_ipaddr   = $urandom;
            req_netmask  = $urandom;
            req_gateway  = $urandom;
            req_targetip = $urandom;
            req_macaddr  = {16'($urandom), $urandom};
            req_clear    = 1'($urandom);
            req_channel  = 4'($urandom);
            @(negedge clk);
        end
        drive(vb);
        t2 = -1;
        for (int i = 0; i < 40 && t2 < 0; i++) begin
            if (req_ready) t2 = cyc;
            else @(negedge clk);
        end
        if (t2 < 0) chk("b2b_accept_timeout", 0, 1);
        else begin
            sbq.push_back('{err: 1'b0, cyc: t2 + 15});
            chk("b2b_accept_cycle", t2, t1 + 16);
        end
        @(negedge clk);
        req_valid = 1'b0;
        wait_idle();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("b2b_a_word%0d", k), mem[24 + k], exp_word(va, k));
            chk($sformatf("b2b_b_word%0d", k), mem[30 + k], exp_word(vb, k));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
